// File: rtl/ina_reg_arbiter_pkg.sv
// Shared register map, reset/ID constants, MASK bit positions and FSM state encoding.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package ina_reg_arbiter_pkg;

  localparam logic [7:0] PTR_CONFIG  = 8'h00;
  localparam logic [7:0] PTR_SHUNT   = 8'h01;
  localparam logic [7:0] PTR_BUS     = 8'h02;
  localparam logic [7:0] PTR_POWER   = 8'h03;
  localparam logic [7:0] PTR_CURRENT = 8'h04;
  localparam logic [7:0] PTR_CAL     = 8'h05;
  localparam logic [7:0] PTR_MASK    = 8'h06;
  localparam logic [7:0] PTR_LIMIT   = 8'h07;
  localparam logic [7:0] PTR_MFG     = 8'hFE;
  localparam logic [7:0] PTR_DIE     = 8'hFF;

  localparam logic [15:0] CFG_RST_DEF = 16'h4127;
  localparam logic [15:0] MFG_ID      = 16'h5449;
  localparam logic [15:0] DIE_ID      = 16'h2260;

  localparam int MASK_CVRF = 3;
  localparam int MASK_CNVR = 10;
  localparam int CFG_SRST  = 15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPT     = 2'd1,
    ST_CALC_CUR = 2'd2,
    ST_CALC_PWR = 2'd3
  } state_e;

endpackage

// File: rtl/ina_reg_arbiter_sat_mul.sv
// 16x16 multiply, right shift and saturate to 16 bits; signed or unsigned mode.
// Latency: combinational.
// Backpressure: none.
module ina_reg_arbiter_sat_mul #(
  parameter int SHIFT_S = 11,
  parameter int SHIFT_U = 12
) (
  input  logic        sgn,
  input  logic [16:0] a_dat,
  input  logic [15:0] b_dat,
  output logic [15:0] res_dat
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] prod_s;
  logic signed [31:0] sh_s;
  logic [32:0]        prod_u;
  logic [32:0]        sh_u;

  // Signed path uses the low 16 bits of a; unsigned path needs a 17-bit magnitude (|-32768|).
  always_comb begin
    a_s     = 32'($signed(a_dat[15:0]));
    b_s     = 32'($signed(b_dat));
    prod_s  = a_s * b_s;
    sh_s    = prod_s >>> SHIFT_S;
    prod_u  = {16'd0, a_dat} * {17'd0, b_dat};
    sh_u    = prod_u >> SHIFT_U;
    res_dat = 16'h0000;
    if (sgn) begin
      if (sh_s > 32'sd32767) begin
        res_dat = 16'h7FFF;
      end else if (sh_s < -32'sd32768) begin
        res_dat = 16'h8000;
      end else begin
        res_dat = sh_s[15:0];
      end
    end else begin
      res_dat = (|sh_u[32:16]) ? 16'hFFFF : sh_u[15:0];
    end
  end

endmodule

// File: rtl/ina_reg_arbiter.sv
// INA226-style register bank: I2C rw access plus measurement sequencer for CURRENT/POWER.
// Latency: reads 1 cycle; a sample updates SHUNT/BUS, CURRENT, POWER over 3 cycles.
// Backpressure: none; one pending sample is buffered while busy, newer overwrites older (meas_ovf).
module ina_reg_arbiter
  import ina_reg_arbiter_pkg::*;
#(
  parameter int          CAL_SHIFT = 11,
  parameter int          PWR_SHIFT = 12,
  parameter logic [15:0] CFG_RST   = CFG_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2c_wr_stb,
  input  logic        i2c_rd_stb,
  input  logic [7:0]  i2c_ptr,
  input  logic [15:0] i2c_wdata,
  output logic [15:0] i2c_rdata,
  output logic        i2c_rvalid,
  output logic        wr_err,
  input  logic        meas_valid,
  input  logic [15:0] meas_shunt,
  input  logic [15:0] meas_bus,
  output logic        meas_ovf,
  output logic        busy,
  output logic        alert_n
);

  state_e      state_q, state_d;
  logic [15:0] config_q, config_d, shunt_q, shunt_d, bus_q, bus_d;
  logic [15:0] power_q, power_d, current_q, current_d, cal_q, cal_d;
  logic [15:0] mask_q, mask_d, limit_q, limit_d, cal_snap_q, cal_snap_d;
  logic [15:0] smp_shunt_q, smp_shunt_d, smp_bus_q, smp_bus_d;
  logic [15:0] pend_shunt_q, pend_shunt_d, pend_bus_q, pend_bus_d;
  logic [15:0] rdata_q, rdata_d;
  logic        pend_vld_q, pend_vld_d, rvalid_q, rvalid_d;
  logic        wr_err_q, wr_err_d, meas_ovf_q, meas_ovf_d;
  logic        soft_rst, cvrf_set;
  logic        mul_sgn;
  logic [16:0] mul_a, cur_ext;
  logic [15:0] mul_b, mul_res;

  // Shared multiplier: signed shunt*cal in CALC_CUR, unsigned |current|*bus otherwise.
  always_comb begin
    cur_ext = {current_q[15], current_q};
    mul_sgn = (state_q == ST_CALC_CUR);
    mul_a   = current_q[15] ? (~cur_ext + 17'd1) : cur_ext;
    mul_b   = bus_q;
    if (state_q == ST_CALC_CUR) begin
      mul_a = {shunt_q[15], shunt_q};
      mul_b = cal_snap_q;
    end
  end

  ina_reg_arbiter_sat_mul #(.SHIFT_S(CAL_SHIFT), .SHIFT_U(PWR_SHIFT)) u_sat_mul (
    .sgn     (mul_sgn),
    .a_dat   (mul_a),
    .b_dat   (mul_b),
    .res_dat (mul_res)
  );

  // Next-state: read mux, I2C writes to rw registers, sequencer writes to ro measurement registers.
  always_comb begin
    state_d      = state_q;
    config_d     = config_q;
    shunt_d      = shunt_q;
    bus_d        = bus_q;
    power_d      = power_q;
    current_d    = current_q;
    cal_d        = cal_q;
    mask_d       = mask_q;
    limit_d      = limit_q;
    cal_snap_d   = cal_snap_q;
    smp_shunt_d  = smp_shunt_q;
    smp_bus_d    = smp_bus_q;
    pend_shunt_d = pend_shunt_q;
    pend_bus_d   = pend_bus_q;
    pend_vld_d   = pend_vld_q;
    rdata_d      = rdata_q;
    rvalid_d     = i2c_rd_stb;
    wr_err_d     = 1'b0;
    meas_ovf_d   = 1'b0;
    soft_rst     = 1'b0;
    cvrf_set     = 1'b0;

    // Read returns the value held this cycle, so a same-cycle write is not visible yet.
    if (i2c_rd_stb) begin
      case (i2c_ptr)
        PTR_CONFIG:  rdata_d = config_q;
        PTR_SHUNT:   rdata_d = shunt_q;
        PTR_BUS:     rdata_d = bus_q;
        PTR_POWER:   rdata_d = power_q;
        PTR_CURRENT: rdata_d = current_q;
        PTR_CAL:     rdata_d = cal_q;
        PTR_MASK:    rdata_d = mask_q;
        PTR_LIMIT:   rdata_d = limit_q;
        PTR_MFG:     rdata_d = MFG_ID;
        PTR_DIE:     rdata_d = DIE_ID;
        default:     rdata_d = 16'h0000;
      endcase
    end

    if (i2c_wr_stb) begin
      case (i2c_ptr)
        PTR_CONFIG: begin
          if (i2c_wdata[CFG_SRST]) soft_rst = 1'b1;
          else                     config_d = i2c_wdata;
        end
        PTR_CAL:   cal_d   = i2c_wdata;
        PTR_MASK:  mask_d  = {i2c_wdata[15:4], mask_q[MASK_CVRF], i2c_wdata[2:0]};
        PTR_LIMIT: limit_d = i2c_wdata;
        default:   wr_err_d = 1'b1;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          smp_shunt_d = pend_shunt_q;
          smp_bus_d   = pend_bus_q;
          pend_vld_d  = 1'b0;
          state_d     = ST_CAPT;
        end else if (meas_valid) begin
          smp_shunt_d = meas_shunt;
          smp_bus_d   = meas_bus;
          state_d     = ST_CAPT;
        end
      end
      ST_CAPT: begin
        shunt_d    = smp_shunt_q;
        bus_d      = smp_bus_q;
        cal_snap_d = cal_q;
        state_d    = ST_CALC_CUR;
      end
      ST_CALC_CUR: begin
        current_d = mul_res;
        state_d   = ST_CALC_PWR;
      end
      ST_CALC_PWR: begin
        power_d  = mul_res;
        cvrf_set = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A sample not taken directly goes to the pending slot; an occupied slot still
    // held (not being drained this cycle) is overwritten.
    if (meas_valid && (state_q != ST_IDLE || pend_vld_q)) begin
      pend_shunt_d = meas_shunt;
      pend_bus_d   = meas_bus;
      pend_vld_d   = 1'b1;
      meas_ovf_d   = pend_vld_q && (state_q != ST_IDLE);
    end

    // CVRF: read-clear of MASK, but a same-cycle conversion-ready set wins.
    if (i2c_rd_stb && i2c_ptr == PTR_MASK) mask_d[MASK_CVRF] = 1'b0;
    if (cvrf_set)                          mask_d[MASK_CVRF] = 1'b1;

    if (soft_rst) begin
      state_d    = ST_IDLE;
      config_d   = CFG_RST;
      shunt_d    = 16'h0;
      bus_d      = 16'h0;
      power_d    = 16'h0;
      current_d  = 16'h0;
      cal_d      = 16'h0;
      mask_d     = 16'h0;
      limit_d    = 16'h0;
      cal_snap_d = 16'h0;
      pend_vld_d = 1'b0;
      meas_ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      config_q     <= CFG_RST;
      shunt_q      <= 16'h0;
      bus_q        <= 16'h0;
      power_q      <= 16'h0;
      current_q    <= 16'h0;
      cal_q        <= 16'h0;
      mask_q       <= 16'h0;
      limit_q      <= 16'h0;
      cal_snap_q   <= 16'h0;
      smp_shunt_q  <= 16'h0;
      smp_bus_q    <= 16'h0;
      pend_shunt_q <= 16'h0;
      pend_bus_q   <= 16'h0;
      pend_vld_q   <= 1'b0;
      rdata_q      <= 16'h0;
      rvalid_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      meas_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      config_q     <= config_d;
      shunt_q      <= shunt_d;
      bus_q        <= bus_d;
      power_q      <= power_d;
      current_q    <= current_d;
      cal_q        <= cal_d;
      mask_q       <= mask_d;
      limit_q      <= limit_d;
      cal_snap_q   <= cal_snap_d;
      smp_shunt_q  <= smp_shunt_d;
      smp_bus_q    <= smp_bus_d;
      pend_shunt_q <= pend_shunt_d;
      pend_bus_q   <= pend_bus_d;
      pend_vld_q   <= pend_vld_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      wr_err_q     <= wr_err_d;
      meas_ovf_q   <= meas_ovf_d;
    end
  end

  assign i2c_rdata  = rdata_q;
  assign i2c_rvalid = rvalid_q;
  assign wr_err     = wr_err_q;
  assign meas_ovf   = meas_ovf_q;
  assign busy       = (state_q != ST_IDLE);
  assign alert_n    = ~(mask_q[MASK_CVRF] & mask_q[MASK_CNVR]);

endmodule

// File: tb/tb_ina_reg_arbiter.sv
// Directed bench with a read scoreboard: reads push expected data, a negedge monitor pops and compares.
module tb_ina_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i2c_wr_stb = 1'b0;
  logic        i2c_rd_stb = 1'b0;
  logic [7:0]  i2c_ptr = 8'h00;
  logic [15:0] i2c_wdata = 16'h0000;
  logic [15:0] i2c_rdata;
  logic        i2c_rvalid;
  logic        wr_err;
  logic        meas_valid = 1'b0;
  logic [15:0] meas_shunt = 16'h0000;
  logic [15:0] meas_bus = 16'h0000;
  logic        meas_ovf;
  logic        busy;
  logic        alert_n;

  int n_chk  = 0;
  int n_fail = 0;
  int ovf_cnt = 0;
  int err_cnt = 0;
  logic        prev_rd = 1'b0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  ina_reg_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_wr_stb (i2c_wr_stb),
    .i2c_rd_stb (i2c_rd_stb),
    .i2c_ptr    (i2c_ptr),
    .i2c_wdata  (i2c_wdata),
    .i2c_rdata  (i2c_rdata),
    .i2c_rvalid (i2c_rvalid),
    .wr_err     (wr_err),
    .meas_valid (meas_valid),
    .meas_shunt (meas_shunt),
    .meas_bus   (meas_bus),
    .meas_ovf   (meas_ovf),
    .busy       (busy),
    .alert_n    (alert_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: rvalid must follow rd_stb by exactly one cycle; data is compared in issue order.
  always @(negedge clk) begin
    if (prev_rd || i2c_rvalid) begin
      n_chk++;
      if (i2c_rvalid !== prev_rd) begin
        n_fail++;
        $display("FAIL rvalid_latency: got %b, expected %b", i2c_rvalid, prev_rd);
      end
    end
    if (i2c_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got data %h, expected no read", i2c_rdata);
      end else begin
        chk(tag_q.pop_front(), i2c_rdata, exp_q.pop_front());
      end
    end
    if (meas_ovf === 1'b1) ovf_cnt++;
    if (wr_err === 1'b1) err_cnt++;
    prev_rd = i2c_rd_stb;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] p, input logic [15:0] exp, input string name);
    exp_q.push_back(exp);
    tag_q.push_back(name);
    i2c_ptr    = p;
    i2c_rd_stb = 1'b1;
    tick();
    i2c_rd_stb = 1'b0;
  endtask

  task automatic wr(input logic [7:0] p, input logic [15:0] d);
    i2c_ptr    = p;
    i2c_wdata  = d;
    i2c_wr_stb = 1'b1;
    tick();
    i2c_wr_stb = 1'b0;
  endtask

  task automatic rdwr(input logic [7:0] p, input logic [15:0] d, input logic [15:0] exp, input string name);
    exp_q.push_back(exp);
    tag_q.push_back(name);
    i2c_ptr    = p;
    i2c_wdata  = d;
    i2c_rd_stb = 1'b1;
    i2c_wr_stb = 1'b1;
    tick();
    i2c_rd_stb = 1'b0;
    i2c_wr_stb = 1'b0;
  endtask

  task automatic smp(input logic [15:0] s, input logic [15:0] b);
    meas_shunt = s;
    meas_bus   = b;
    meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held low.
    #8;
    chk("rst_rdata", i2c_rdata, 16'h0000);
    chk("rst_rvalid", {15'd0, i2c_rvalid}, 16'd0);
    chk("rst_alert_n", {15'd0, alert_n}, 16'd1);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    #14 rst = 1'b1;
    tick();

    // Reset register values.
    rd(8'h00, 16'h4127, "rst_config");
    rd(8'h05, 16'h0000, "rst_cal");
    rd(8'hFE, 16'h5449, "rst_mfg");
    rd(8'hFF, 16'h2260, "rst_die");
    rd(8'h06, 16'h0000, "rst_mask");

    // Basic calculation: 0x100*0x800>>11 = 0x100; 0x100*0x1000>>12 = 0x100.
    wr(8'h05, 16'h0800);
    smp(16'h0100, 16'h1000);
    chk("calc_busy", {15'd0, busy}, 16'd1);
    repeat (3) tick();
    chk("calc_idle", {15'd0, busy}, 16'd0);
    rd(8'h04, 16'h0100, "calc_current");
    rd(8'h03, 16'h0100, "calc_power");
    rd(8'h01, 16'h0100, "calc_shunt");
    rd(8'h02, 16'h1000, "calc_bus");
    rd(8'h06, 16'h0008, "calc_cvrf");
    rd(8'h06, 16'h0000, "cvrf_cleared");

    // Saturation: 0x7FFF*-32768>>>11 -> -32768; 32768*0xFFFF>>12 = 0x7FFF8 -> 0xFFFF.
    wr(8'h05, 16'h7FFF);
    smp(16'h8000, 16'hFFFF);
    repeat (3) tick();
    rd(8'h04, 16'h8000, "sat_current");
    rd(8'h03, 16'hFFFF, "sat_power");

    // Back-to-back: three consecutive samples, middle one overwritten in pending.
    ovf_cnt = 0;
    meas_valid = 1'b1;
    meas_shunt = 16'h0010; meas_bus = 16'h0001; tick();
    meas_shunt = 16'h0020; meas_bus = 16'h0002; tick();
    meas_shunt = 16'h0030; meas_bus = 16'h0003; tick();
    meas_valid = 1'b0;
    repeat (4) tick();
    chk("b2b_busy_last", {15'd0, busy}, 16'd1);
    tick();
    chk("b2b_busy_done", {15'd0, busy}, 16'd0);
    chk("b2b_ovf_cnt", 16'(ovf_cnt), 16'd1);
    rd(8'h01, 16'h0030, "b2b_shunt");
    rd(8'h02, 16'h0003, "b2b_bus");
    // 48*32767 = 1572816, >>11 = 767.
    rd(8'h04, 16'h02FF, "b2b_current");

    // Same-cycle read and write on one pointer returns the old value.
    wr(8'h07, 16'h1111);
    rdwr(8'h07, 16'h2222, 16'h1111, "rdwr_old");
    rd(8'h07, 16'h2222, "rdwr_new");

    // Access errors.
    err_cnt = 0;
    wr(8'h01, 16'h1234);
    wr(8'h42, 16'h1234);
    tick();
    chk("wr_err_cnt", 16'(err_cnt), 16'd2);
    rd(8'h01, 16'h0030, "ro_unchanged");
    rd(8'h42, 16'h0000, "unmapped_read");

    // Soft reset through CONFIG bit15 in the middle of a calculation.
    smp(16'h0100, 16'h1000);
    tick();
    wr(8'h00, 16'h8000);
    chk("srst_busy", {15'd0, busy}, 16'd0);
    rd(8'h00, 16'h4127, "srst_config");
    rd(8'h05, 16'h0000, "srst_cal");
    rd(8'h01, 16'h0000, "srst_shunt");
    rd(8'h07, 16'h0000, "srst_limit");
    repeat (3) tick();
    rd(8'h04, 16'h0000, "srst_current");

    // Alert path.
    wr(8'h05, 16'h0800);
    wr(8'h06, 16'h0400);
    chk("alert_pre", {15'd0, alert_n}, 16'd1);
    smp(16'h0100, 16'h1000);
    repeat (3) tick();
    chk("alert_low", {15'd0, alert_n}, 16'd0);
    rd(8'h06, 16'h0408, "alert_mask");
    chk("alert_high", {15'd0, alert_n}, 16'd1);

    // Asynchronous reset mid-calculation with a pending sample.
    smp(16'h0200, 16'h1000);
    smp(16'h0300, 16'h1000);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_rdata", i2c_rdata, 16'h0000);
    #3 rst = 1'b1;
    tick();
    repeat (5) begin
      chk("arst_no_pending", {15'd0, busy}, 16'd0);
      tick();
    end
    rd(8'h01, 16'h0000, "arst_shunt");
    rd(8'h00, 16'h4127, "arst_config");

    repeat (3) tick();
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
